// File: rtl/surf_dout_pkg.sv
// Shared types and constants for the SURF DOUT event packer.
// Trailer layout, FSM states and byte-lane keep helpers.
package surf_dout_pkg;

  localparam int BCNT_W  = 16;
  localparam int EVNUM_W = 12;

  typedef struct packed {
    logic [3:0]         surf_id;
    logic [EVNUM_W-1:0] evnum;
    logic [BCNT_W-1:0]  bytecount;
  } trailer_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PACK    = 2'd1,
    TRAILER = 2'd2
  } state_t;

  // Indexed by (lanes filled - 1): 1, 3, 7, F
  localparam logic [15:0] KEEP_LUT = 16'hF731;

  function automatic logic [3:0] keep_of(
    input logic [1:0] last_lane
  );
    return KEEP_LUT[4*last_lane +: 4];
  endfunction

  function automatic logic [31:0] keep_mask(
    input logic [3:0] k
  );
    return {{8{k[3]}}, {8{k[2]}},
            {8{k[1]}}, {8{k[0]}}};
  endfunction

endpackage

// File: rtl/surf_dout_event_packer.sv
// Packs the 8-bit DOUT event stream into 32-bit words
// and appends one trailer word per event.
module surf_dout_event_packer #(
  parameter logic [3:0]  SURF_ID   = 4'h0,
  parameter logic [15:0] MAX_BYTES = 16'd49152
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        event_reset_i,
  input  logic [7:0]  s_dout_tdata,
  input  logic        s_dout_tvalid,
  output logic        s_dout_tready,
  input  logic        s_dout_tlast,
  output logic [31:0] m_evt_tdata,
  output logic [3:0]  m_evt_tkeep,
  output logic        m_evt_tvalid,
  input  logic        m_evt_tready,
  output logic        m_evt_tlast,
  output logic        m_evt_tuser,
  output logic        trunc_o
);
  import surf_dout_pkg::*;

  state_t             r_state;
  state_t             w_state_nx;
  logic [1:0]         r_lane;
  logic [31:0]        r_acc;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [EVNUM_W-1:0] r_evnum;
  logic               r_trunc;
  logic               r_trunc_p;
  logic               r_up;

  logic [31:0] r_mdata;
  logic [3:0]  r_mkeep;
  logic        r_mvalid;
  logic        r_mlast;
  logic        r_muser;

  logic        w_oready;
  logic        w_sready;
  logic        w_acc;
  logic        w_store;
  logic        w_drop;
  logic        w_ld_word;
  logic        w_ld_trl;
  logic [31:0] w_word;
  logic [3:0]  w_ld_keep;
  logic [31:0] w_ld_data;
  trailer_t    w_trl;

  logic [31:0] w_o_data;
  logic [3:0]  w_o_keep;
  logic        w_o_valid;
  logic        w_o_last;
  logic        w_o_user;

  assign w_oready = !r_mvalid || m_evt_tready;
  // r_up keeps tready low on the first cycle out of reset
  assign w_sready = r_up && !event_reset_i
                 && (r_state != TRAILER) && w_oready;
  assign w_acc    = s_dout_tvalid && w_sready;
  assign w_store  = w_acc && (r_bcnt < MAX_BYTES);
  assign w_drop   = w_acc && !w_store;

  assign w_ld_word = (w_store && (r_lane == 2'd3 || s_dout_tlast))
                  || (w_drop && s_dout_tlast && r_lane != 2'd0);
  assign w_ld_trl  = (r_state == TRAILER) && w_oready;

  assign w_trl = '{surf_id:   SURF_ID,
                   evnum:     r_evnum,
                   bytecount: r_bcnt};

  always_comb begin
    w_word = r_acc;
    w_word[8*r_lane +: 8] = s_dout_tdata;
  end

  // Stored byte closes the word; a dropped tlast flushes what is held
  always_comb begin
    w_ld_keep = keep_of(r_lane - 2'd1);
    w_ld_data = r_acc & keep_mask(w_ld_keep);
    if (w_store) begin
      w_ld_keep = keep_of(r_lane);
      w_ld_data = w_word & keep_mask(w_ld_keep);
    end
  end

  always_comb begin
    w_o_data  = r_mdata;
    w_o_keep  = r_mkeep;
    w_o_valid = r_mvalid && !m_evt_tready;
    w_o_last  = r_mlast;
    w_o_user  = r_muser;
    unique case (1'b1)
      w_ld_trl: begin
        w_o_data  = w_trl;
        w_o_keep  = 4'hF;
        w_o_valid = 1'b1;
        w_o_last  = 1'b1;
        w_o_user  = r_trunc;
      end
      w_ld_word: begin
        w_o_data  = w_ld_data;
        w_o_keep  = w_ld_keep;
        w_o_valid = 1'b1;
        w_o_last  = 1'b0;
        w_o_user  = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:
        if (w_acc)
          w_state_nx = s_dout_tlast ? TRAILER : PACK;
      PACK:
        if (w_acc && s_dout_tlast)
          w_state_nx = TRAILER;
      TRAILER:
        if (w_ld_trl)
          w_state_nx = IDLE;
      default:
        w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_lane    <= 2'd0;
      r_acc     <= '0;
      r_bcnt    <= '0;
      r_evnum   <= '0;
      r_trunc   <= 1'b0;
      r_trunc_p <= 1'b0;
      r_up      <= 1'b0;
      r_mdata   <= '0;
      r_mkeep   <= '0;
      r_mvalid  <= 1'b0;
      r_mlast   <= 1'b0;
      r_muser   <= 1'b0;
    end else if (event_reset_i) begin
      r_state   <= IDLE;
      r_lane    <= 2'd0;
      r_acc     <= '0;
      r_bcnt    <= '0;
      r_evnum   <= '0;
      r_trunc   <= 1'b0;
      r_trunc_p <= 1'b0;
      r_up      <= 1'b1;
      r_mdata   <= '0;
      r_mkeep   <= '0;
      r_mvalid  <= 1'b0;
      r_mlast   <= 1'b0;
      r_muser   <= 1'b0;
    end else begin
      r_up      <= 1'b1;
      r_state   <= w_state_nx;
      r_trunc_p <= w_drop && !r_trunc;
      r_mdata   <= w_o_data;
      r_mkeep   <= w_o_keep;
      r_mvalid  <= w_o_valid;
      r_mlast   <= w_o_last;
      r_muser   <= w_o_user;
      if (w_store) begin
        r_bcnt <= r_bcnt + 16'd1;
        if (r_lane == 2'd3 || s_dout_tlast) begin
          r_lane <= 2'd0;
          r_acc  <= '0;
        end else begin
          r_lane <= r_lane + 2'd1;
          r_acc  <= w_word;
        end
      end
      if (w_drop) begin
        r_trunc <= 1'b1;
        if (s_dout_tlast) begin
          r_lane <= 2'd0;
          r_acc  <= '0;
        end
      end
      if (w_ld_trl) begin
        r_evnum <= r_evnum + 12'd1;
        r_bcnt  <= '0;
        r_trunc <= 1'b0;
      end
    end
  end

  assign s_dout_tready = w_sready;
  assign m_evt_tdata   = r_mdata;
  assign m_evt_tkeep   = r_mkeep;
  assign m_evt_tvalid  = r_mvalid;
  assign m_evt_tlast   = r_mlast;
  assign m_evt_tuser   = r_muser;
  assign trunc_o       = r_trunc_p;

endmodule

// File: tb/tb_surf_dout_event_packer.sv
// Bench for surf_dout_event_packer: table-driven events,
// scoreboard queues, stall, truncation, reset and wrap cases.
module tb_surf_dout_event_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_evr, a_sv, a_sr, a_sl, a_mv, a_mr, a_ml, a_mu, a_tr;
  logic [7:0]  a_sd;
  logic [31:0] a_md;
  logic [3:0]  a_mk;

  logic        b_evr, b_sv, b_sr, b_sl, b_mv, b_mr, b_ml, b_mu, b_tr;
  logic [7:0]  b_sd;
  logic [31:0] b_md;
  logic [3:0]  b_mk;

  surf_dout_event_packer dut_a (
    .aclk(clk), .aresetn(rst_n), .event_reset_i(a_evr),
    .s_dout_tdata(a_sd), .s_dout_tvalid(a_sv),
    .s_dout_tready(a_sr), .s_dout_tlast(a_sl),
    .m_evt_tdata(a_md), .m_evt_tkeep(a_mk),
    .m_evt_tvalid(a_mv), .m_evt_tready(a_mr),
    .m_evt_tlast(a_ml), .m_evt_tuser(a_mu), .trunc_o(a_tr)
  );

  surf_dout_event_packer #(
    .SURF_ID(4'h5), .MAX_BYTES(16'd6)
  ) dut_b (
    .aclk(clk), .aresetn(rst_n), .event_reset_i(b_evr),
    .s_dout_tdata(b_sd), .s_dout_tvalid(b_sv),
    .s_dout_tready(b_sr), .s_dout_tlast(b_sl),
    .m_evt_tdata(b_md), .m_evt_tkeep(b_mk),
    .m_evt_tvalid(b_mv), .m_evt_tready(b_mr),
    .m_evt_tlast(b_ml), .m_evt_tuser(b_mu), .trunc_o(b_tr)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } wd_t;

  typedef struct {
    int          n;
    logic [7:0]  base;
    logic [7:0]  step;
    int          nw;
    logic [2:0][31:0] w;
    logic [2:0][3:0]  k;
    logic [31:0] trl;
  } vec_t;

  wd_t qa[$];
  wd_t qb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  wd_t a_cur, b_cur;
  assign a_cur = {a_md, a_mk, a_ml, a_mu};
  assign b_cur = {b_md, b_mk, b_ml, b_mu};

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout want completion", nm);
  endtask

  // Scoreboard and stall checks for dut_a
  logic a_stall = 1'b0;
  wd_t  a_hold;
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_stall)
        chk("a_stable", a_cur, a_hold);
      if (a_mv && !a_mr)
        chk("a_sready_held", {63'b0, a_sr}, 64'd0);
      if (a_mv && a_mr) begin
        if (qa.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_unexpected: got %0h want none", a_cur);
        end else begin
          chk("a_word", a_cur, qa.pop_front());
        end
      end
      a_stall <= a_mv && !a_mr;
      a_hold  <= a_cur;
    end
  end

  // Scoreboard and truncation pulse tracking for dut_b
  int b_acc = 0;
  int b_ntr = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_tr) begin
        b_ntr <= b_ntr + 1;
        chk("b_trunc_pos", 64'(b_acc), 64'd7);
      end
      if (b_sv && b_sr)
        b_acc <= b_acc + 1;
      if (b_mv && b_mr) begin
        if (qb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_unexpected: got %0h want none", b_cur);
        end else begin
          chk("b_word", b_cur, qb.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit sel, input logic v,
                       input logic [7:0] d, input logic l);
    if (sel) begin
      b_sv = v; b_sd = d; b_sl = l;
    end else begin
      a_sv = v; a_sd = d; a_sl = l;
    end
  endtask

  task automatic send_evt(input bit sel, input int n,
                          input logic [7:0] base,
                          input logic [7:0] step,
                          input bit do_last);
    logic [7:0] bv;
    int t;
    bv = base;
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'b1, bv, do_last && (i == n - 1));
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(sel ? b_sr : a_sr) && t < 200);
      if (t >= 200) bound_fail("send_tready");
      @(posedge clk);
      #1;
      bv = bv + step;
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input bit sel);
    int t;
    t = 0;
    while (((sel ? qb.size() : qa.size()) != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) bound_fail(sel ? "b_drain" : "a_drain");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic u);
    qa.push_back({d, k, l, u});
  endtask

  task automatic push_b(input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic u);
    qb.push_back({d, k, l, u});
  endtask

  vec_t       tbl[6];
  bit         done;
  logic [3:0] pat;
  logic [7:0] bb;
  logic [11:0] ev;

  initial begin
    tbl[0] = '{8, 8'h00, 8'h01, 2,
               {32'h0, 32'h07060504, 32'h03020100},
               {4'h0, 4'hF, 4'hF}, 32'h0000_0008};
    tbl[1] = '{5, 8'hAA, 8'h11, 2,
               {32'h0, 32'h000000EE, 32'hDDCCBBAA},
               {4'h0, 4'h1, 4'hF}, 32'h0001_0005};
    tbl[2] = '{4, 8'h10, 8'h01, 1,
               {32'h0, 32'h0, 32'h13121110},
               {4'h0, 4'h0, 4'hF}, 32'h0002_0004};
    tbl[3] = '{1, 8'h5A, 8'h01, 1,
               {32'h0, 32'h0, 32'h0000005A},
               {4'h0, 4'h0, 4'h1}, 32'h0003_0001};
    tbl[4] = '{3, 8'h01, 8'h02, 1,
               {32'h0, 32'h0, 32'h00050301},
               {4'h0, 4'h0, 4'h7}, 32'h0004_0003};
    tbl[5] = '{7, 8'h80, 8'h01, 2,
               {32'h0, 32'h00868584, 32'h83828180},
               {4'h0, 4'h7, 4'hF}, 32'h0005_0007};

    rst_n = 1'b0;
    a_evr = 0; a_sv = 0; a_sd = 0; a_sl = 0; a_mr = 1;
    b_evr = 0; b_sv = 0; b_sd = 0; b_sl = 0; b_mr = 1;
    repeat (3) @(negedge clk);
    chk("a_reset_outs",
        {a_sr, a_mv, a_md, a_mk, a_ml, a_mu, a_tr}, 64'd0);
    chk("b_reset_outs",
        {b_sr, b_mv, b_md, b_mk, b_ml, b_mu, b_tr}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < tbl[i].nw; j++)
        push_a(tbl[i].w[j], tbl[i].k[j], 1'b0, 1'b0);
      push_a(tbl[i].trl, 4'hF, 1'b1, 1'b0);
      send_evt(1'b0, tbl[i].n, tbl[i].base, tbl[i].step, 1'b1);
      drain(1'b0);
    end

    // Downstream stalls 1-0-0-1 during a 12-byte event
    push_a(32'h23222120, 4'hF, 1'b0, 1'b0);
    push_a(32'h27262524, 4'hF, 1'b0, 1'b0);
    push_a(32'h2B2A2928, 4'hF, 1'b0, 1'b0);
    push_a(32'h0006000C, 4'hF, 1'b1, 1'b0);
    pat  = 4'b1001;
    done = 1'b0;
    fork
      begin
        send_evt(1'b0, 12, 8'h20, 8'h01, 1'b1);
        done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!done) begin
          a_mr = pat[k % 4];
          k++;
          @(posedge clk);
          #1;
        end
      end
    join
    a_mr = 1'b1;
    drain(1'b0);

    // Abort after 3 bytes; no output and evnum restarts
    send_evt(1'b0, 3, 8'h61, 8'h01, 1'b0);
    a_evr = 1'b1;
    drive(1'b0, 1'b1, 8'h99, 1'b1);
    @(negedge clk);
    chk("a_sready_evr", {63'b0, a_sr}, 64'd0);
    @(posedge clk);
    #1;
    a_evr = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("a_idle_after_evr", {63'b0, a_mv}, 64'd0);
    @(posedge clk);
    #1;
    push_a(32'hC3C2C1C0, 4'hF, 1'b0, 1'b0);
    push_a(32'h00000004, 4'hF, 1'b1, 1'b0);
    send_evt(1'b0, 4, 8'hC0, 8'h01, 1'b1);
    drain(1'b0);

    // 4096 one-byte events: evnum runs 1..4095 then wraps to 0
    ev = 12'd1;
    for (int i = 0; i < 4096; i++) begin
      bb = 8'(i);
      push_a({24'h0, bb}, 4'h1, 1'b0, 1'b0);
      push_a({4'h0, ev, 16'd1}, 4'hF, 1'b1, 1'b0);
      ev = ev + 12'd1;
      send_evt(1'b0, 1, bb, 8'h00, 1'b1);
    end
    drain(1'b0);

    // Truncation on the MAX_BYTES=6 instance
    push_b(32'h33323130, 4'hF, 1'b0, 1'b0);
    push_b(32'h00003534, 4'h3, 1'b0, 1'b0);
    push_b(32'h50000006, 4'hF, 1'b1, 1'b1);
    send_evt(1'b1, 10, 8'h30, 8'h01, 1'b1);
    drain(1'b1);
    chk("b_trunc_once", 64'(b_ntr), 64'd1);

    push_b(32'h00004140, 4'h3, 1'b0, 1'b0);
    push_b(32'h50010002, 4'hF, 1'b1, 1'b0);
    send_evt(1'b1, 2, 8'h40, 8'h01, 1'b1);
    drain(1'b1);
    chk("b_trunc_cleared", 64'(b_ntr), 64'd1);

    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
